// File: rtl/servo_pwm_pkg.sv
// rtl/servo_pwm_pkg.sv - servo_pwm_array register map, types and helpers (SERVO_SLEW_EN adds the slew status address)
package servo_pwm_pkg;

  localparam int PW_W_DEF = 16;
  typedef logic [PW_W_DEF-1:0] pw_t;

  localparam int CTRL_ADDR   = 0;
  localparam int PERIOD_ADDR = 1;
  localparam int TARGET_BASE = 2;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_STICKY_BIT = 1;

  // The slew build appends a status word after the TARGET block.
  function automatic int addr_w(input int num_ch);
`ifdef SERVO_SLEW_EN
    return $clog2(num_ch + 3);
`else
    return $clog2(num_ch + 2);
`endif
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_pwm_array_if.sv
// rtl/servo_pwm_array_if.sv - Avalon-MM slave bus for servo_pwm_array (address width follows SERVO_SLEW_EN)
interface servo_pwm_array_if #(
  parameter int NUM_CH = 8
);
  import servo_pwm_pkg::*;

  localparam int ADDR_W = addr_w(NUM_CH);

  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );

endinterface

// File: rtl/servo_pwm_chan.sv
// rtl/servo_pwm_chan.sv - one servo channel: target, frame-aligned active width, comparator (SERVO_SLEW_EN rate-limits updates)
module servo_pwm_chan
  import servo_pwm_pkg::*;
#(
  parameter int PW_W      = PW_W_DEF,
  parameter int MIN_PW    = 1000,
  parameter int SLEW_STEP = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr,
  input  logic [PW_W-1:0] wr_pw,
  input  logic            frame_start,
  input  logic            out_en,
  input  logic [PW_W-1:0] cnt,
  output logic [PW_W-1:0] target,
`ifdef SERVO_SLEW_EN
  output logic            busy,
`endif
  output logic            pwm
);

  logic [PW_W-1:0] active;
  logic [PW_W-1:0] next_active;

`ifdef SERVO_SLEW_EN
  localparam logic [PW_W-1:0] STEP = PW_W'(SLEW_STEP);

  always_comb begin
    next_active = target;
    if ((target > active) && ((target - active) > STEP))
      next_active = active + STEP;
    else if ((target < active) && ((active - target) > STEP))
      next_active = active - STEP;
  end

  assign busy = (active != target);
`else
  assign next_active = target;
`endif

  // active only changes at frame start, so a pulse in flight is never cut or stretched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target <= PW_W'(MIN_PW);
      active <= PW_W'(MIN_PW);
      pwm    <= 1'b0;
    end else begin
      if (wr)
        target <= wr_pw;
      if (frame_start)
        active <= next_active;
      pwm <= out_en && (cnt < active);
    end
  end

endmodule

// File: rtl/servo_pwm_array.sv
// rtl/servo_pwm_array.sv - N-channel servo PWM generator with Avalon-MM registers (optional SERVO_SLEW_EN)
module servo_pwm_array
  import servo_pwm_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int PW_W       = PW_W_DEF,
  parameter int CLK_DIV    = 50,
  parameter int PERIOD_RST = 20000,
  parameter int MIN_PW     = 1000,
  parameter int MAX_PW     = 2000,
  parameter int SLEW_STEP  = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  servo_pwm_array_if.slave    avs,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                frame_irq
);

  localparam int ADDR_W = addr_w(NUM_CH);
  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic                        en;
  logic                        sticky;
  logic [PW_W-1:0]             period;
  logic [PW_W-1:0]             period_sh;
  logic [PW_W-1:0]             cnt;
  logic [PRE_W-1:0]            presc;
  logic [NUM_CH-1:0][PW_W-1:0] target;
  logic [NUM_CH-1:0]           chan_wr;
`ifdef SERVO_SLEW_EN
  logic [NUM_CH-1:0]           busy;
`endif

  logic            ctrl_wr;
  logic            period_wr;
  logic            en_nxt;
  logic            en_rise;
  logic            tick;
  logic            wrap;
  logic            frame_start;
  logic            out_en;
  logic [PW_W-1:0] wr_pw;
  logic [PW_W-1:0] tgt_pw;
  logic [PW_W-1:0] per_pw;
  logic [31:0]     rd_mux;

  assign ctrl_wr   = avs.avs_write && (avs.avs_address == ADDR_W'(CTRL_ADDR));
  assign period_wr = avs.avs_write && (avs.avs_address == ADDR_W'(PERIOD_ADDR));

  assign wr_pw  = avs.avs_writedata[PW_W-1:0];
  assign tgt_pw = PW_W'(clamp(32'(wr_pw), 32'(MIN_PW), 32'(MAX_PW)));
  assign per_pw = PW_W'(clamp(32'(wr_pw), 32'(MAX_PW + 1), 32'hFFFF_FFFF));

  // The enabling write itself starts the first frame, so counting begins from 0 with EN=1.
  assign en_nxt      = ctrl_wr ? avs.avs_writedata[CTRL_EN_BIT] : en;
  assign en_rise     = en_nxt && !en;
  assign tick        = en && (presc == PRE_W'(CLK_DIV - 1));
  assign wrap        = tick && (cnt == period_sh - 1'b1);
  assign frame_start = en_rise || (en_nxt && wrap);
  assign out_en      = en && en_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en        <= 1'b0;
      sticky    <= 1'b0;
      period    <= PW_W'(PERIOD_RST);
      period_sh <= PW_W'(PERIOD_RST);
      cnt       <= '0;
      presc     <= '0;
      frame_irq <= 1'b0;
    end else begin
      frame_irq <= frame_start;
      if (ctrl_wr)
        en <= avs.avs_writedata[CTRL_EN_BIT];
      if (frame_start)
        sticky <= 1'b1;
      else if (ctrl_wr && avs.avs_writedata[CTRL_STICKY_BIT])
        sticky <= 1'b0;
      if (period_wr)
        period <= per_pw;
      if (frame_start)
        period_sh <= period;
      if (!en_nxt || en_rise) begin
        presc <= '0;
        cnt   <= '0;
      end else if (tick) begin
        presc <= '0;
        cnt   <= wrap ? '0 : cnt + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign chan_wr[i] = avs.avs_write && (avs.avs_address == ADDR_W'(TARGET_BASE + i));

    servo_pwm_chan #(
      .PW_W      (PW_W),
      .MIN_PW    (MIN_PW),
      .SLEW_STEP (SLEW_STEP)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr          (chan_wr[i]),
      .wr_pw       (tgt_pw),
      .frame_start (frame_start),
      .out_en      (out_en),
      .cnt         (cnt),
      .target      (target[i]),
`ifdef SERVO_SLEW_EN
      .busy        (busy[i]),
`endif
      .pwm         (pwm_out[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (avs.avs_address == ADDR_W'(CTRL_ADDR)) begin
      rd_mux[CTRL_EN_BIT]     = en;
      rd_mux[CTRL_STICKY_BIT] = sticky;
    end else if (avs.avs_address == ADDR_W'(PERIOD_ADDR)) begin
      rd_mux[PW_W-1:0] = period;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (avs.avs_address == ADDR_W'(TARGET_BASE + i))
        rd_mux[PW_W-1:0] = target[i];
    end
`ifdef SERVO_SLEW_EN
    if (avs.avs_address == ADDR_W'(TARGET_BASE + NUM_CH))
      rd_mux[NUM_CH-1:0] = busy;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      avs.avs_readdata <= '0;
    else if (avs.avs_read)
      avs.avs_readdata <= rd_mux;
  end

endmodule
